// File: rtl/fir_decimator.sv
// ----------------------------------------------------------------------------
// fir_decimator
//   Accumulate-and-dump decimator placed after filterfir. It sums DECIM
//   consecutive strobed samples and emits their mean through a one-entry
//   output register with a valid/ready handshake. A sticky overrun flag
//   records any result that was dropped because the output register was
//   still full.
//
// Build option
//   FIR_DECIM_ROUND_EN : when defined, the mean is rounded half up
//                        ((sum + DECIM/2) >> LOG2_DECIM); when undefined, the
//                        mean is truncated (sum >> LOG2_DECIM).
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din         unsigned input sample (filterfir dataout)
//   din_en      sample strobe; din is consumed on the clock edge when high
//   clr         synchronous clear of the frame, valid flag and overrun flag
//   dout        decimated (mean) sample
//   dout_valid  dout holds an unconsumed result
//   dout_ready  consumer accepts dout when dout_valid & dout_ready
//   overrun     sticky: a result was dropped while the output was full
// ----------------------------------------------------------------------------
module fir_decimator #(
    parameter int DIN_W      = 10,
    parameter int DECIM      = 4,
    parameter int LOG2_DECIM = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] din,
    input  logic             din_en,
    input  logic             clr,
    output logic [DIN_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    // Sum of DECIM full-scale samples fits exactly, so the accumulator never wraps.
    localparam int ACC_W = DIN_W + LOG2_DECIM;

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [LOG2_DECIM-1:0] phase_q, phase_d;
    logic [DIN_W-1:0]      dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overrun_q, overrun_d;

    logic                  last_phase;
    logic                  dump;
    logic                  drain;
    logic [ACC_W-1:0]      sum;
    logic [ACC_W-1:0]      rounded;
    logic [DIN_W-1:0]      result;

    assign last_phase = (phase_q == LOG2_DECIM'(DECIM - 1));
    assign dump       = din_en & last_phase;
    assign drain      = dout_valid_q & dout_ready;
    assign sum        = acc_q + ACC_W'(din);

`ifdef FIR_DECIM_ROUND_EN
    // Max sum plus DECIM/2 is still below 2^ACC_W, so the rounding add cannot carry out.
    assign rounded = sum + ACC_W'(DECIM / 2);
`else
    assign rounded = sum;
`endif

    // Upper LOG2_DECIM bits of the shifted value are always zero.
    assign result = DIN_W'(rounded >> LOG2_DECIM);

    always_comb begin
        acc_d        = acc_q;
        phase_d      = phase_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        if (clr) begin
            // Clear wins over any strobe or dump on the same edge; dout value is kept.
            acc_d        = '0;
            phase_d      = '0;
            dout_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            if (din_en) begin
                if (last_phase) begin
                    acc_d   = '0;
                    phase_d = '0;
                end else begin
                    acc_d   = sum;
                    phase_d = phase_q + LOG2_DECIM'(1);
                end
            end

            if (dump) begin
                // A drain on the same edge frees the register, so the new result loads.
                if (!dout_valid_q || drain) begin
                    dout_d       = result;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (drain) begin
                dout_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            phase_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_decimator.sv
// ----------------------------------------------------------------------------
// tb_fir_decimator
//   Directed bench for fir_decimator (DECIM=4). Stimulus pushes hand-computed
//   results into a queue; a monitor pops and compares on every handshake.
//   Status flags (dout_valid, overrun, reset values) are checked inline.
// ----------------------------------------------------------------------------
module tb_fir_decimator;

    localparam int DIN_W = 10;

`ifdef FIR_DECIM_ROUND_EN
    localparam int EXP_T1 = 11;   // (42 + 2) >> 2
    localparam int EXP_T1B = 3;   // (10 + 2) >> 2
`else
    localparam int EXP_T1 = 10;   // 42 >> 2
    localparam int EXP_T1B = 2;   // 10 >> 2
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIN_W-1:0] din = '0;
    logic             din_en = 1'b0;
    logic             clr = 1'b0;
    logic [DIN_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b1;
    logic             overrun;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_q[$];

    fir_decimator #(.DIN_W(DIN_W), .DECIM(4), .LOG2_DECIM(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input int v);
        din    = DIN_W'(v);
        din_en = 1'b1;
        @(posedge clk);
        #1;
        din_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: a transfer is committed on the next rising edge.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_out: got dout=%0d, expected no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", int'(dout), e);
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // 1: basic mean and one-cycle valid pulse
        exp_q.push_back(EXP_T1);
        strobe(5); strobe(10); strobe(12);
        chk("t1_valid_early", int'(dout_valid), 0);
        strobe(15);
        chk("t1_valid_after_dump", int'(dout_valid), 1);
        idle(1);
        chk("t1_valid_pulse_end", int'(dout_valid), 0);
        exp_q.push_back(EXP_T1B);
        strobe(1); strobe(2); strobe(3); strobe(4);
        wait_drain("t1_drain");

        // 2: gaps between strobes
        exp_q.push_back(16);
        for (int i = 0; i < 4; i++) begin
            strobe(16);
            if (i < 3) idle(3);
        end
        wait_drain("t2_drain");

        // 3: output stalled -> overrun, held value
        dout_ready = 1'b0;
        exp_q.push_back(100);
        for (int i = 0; i < 8; i++) strobe(100);
        for (int i = 0; i < 8; i++) strobe(200);
        chk("t3_overrun", int'(overrun), 1);
        chk("t3_dout_held", int'(dout), 100);
        chk("t3_valid_held", int'(dout_valid), 1);
        dout_ready = 1'b1;
        idle(1);
        chk("t3_valid_after", int'(dout_valid), 0);
        chk("t3_overrun_sticky", int'(overrun), 1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("t3_overrun_clr", int'(overrun), 0);

        // 4: drain and dump on the same edge
        dout_ready = 1'b0;
        exp_q.push_back(20);
        exp_q.push_back(40);
        for (int i = 0; i < 4; i++) strobe(20);
        for (int i = 0; i < 3; i++) strobe(40);
        dout_ready = 1'b1;
        strobe(40);
        chk("t4_valid_backtoback", int'(dout_valid), 1);
        chk("t4_dout_40", int'(dout), 40);
        wait_drain("t4_drain");
        chk("t4_overrun", int'(overrun), 0);

        // 5: clr with a coincident strobe discards the partial frame and overrun
        dout_ready = 1'b0;
        exp_q.push_back(3);
        for (int i = 0; i < 8; i++) strobe(3);
        dout_ready = 1'b1;
        wait_drain("t5_pre_drain");
        chk("t5_overrun_set", int'(overrun), 1);
        strobe(1023); strobe(1023);
        din = 10'd1023; din_en = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1;
        din_en = 1'b0; clr = 1'b0;
        chk("t5_overrun_cleared", int'(overrun), 0);
        chk("t5_valid_cleared", int'(dout_valid), 0);
        exp_q.push_back(8);
        for (int i = 0; i < 4; i++) strobe(8);
        wait_drain("t5_drain");

        // 6: asynchronous reset mid-frame
        strobe(1023); strobe(1023); strobe(1023);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_dout", int'(dout), 0);
        chk("t6_rst_valid", int'(dout_valid), 0);
        chk("t6_rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(1023);
        for (int i = 0; i < 4; i++) strobe(1023);
        wait_drain("t6_drain");

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
